// File: rtl/riscv_definitions_pkg.sv
// Shared fetch-path definitions: prefetch FSM states, queue entry layout, NOP encoding.
package riscv_definitions;

  localparam int unsigned FETCH_XLEN = 32;

  // addi x0, x0, 0
  localparam logic [FETCH_XLEN-1:0] NOP_INSTRUCTION = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DROP
  } prefetchState_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } fetchEntry_t;

endpackage

// File: rtl/instruction_prefetch_queue_fifo.sv
// Circular buffer holding fetched {pc, inst} pairs; flush empties it in one cycle.
module prefetch_fifo
  import riscv_definitions::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetchEntry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wr_data,
  output entry_t                 rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [PtrW:0] CntOne = 1;
  localparam logic [PtrW:0] CntFull = DEPTH;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]   count_q;

  // Pointers and occupancy; flush wins over push/pop, pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clk_en) begin
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
        if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
        if (push && !pop) count_q <= count_q + CntOne;
        else if (pop && !push) count_q <= count_q - CntOne;
      end
    end
  end

  // Entry storage; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (clk_en && push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CntFull);
  assign empty   = (count_q == '0);

endmodule

// File: rtl/instruction_prefetch_queue.sv
// Sequential instruction prefetcher: fetch FSM plus a small queue feeding decode.
module instruction_prefetch_queue
  import riscv_definitions::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            inst_ready,
  input  logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_addr,
  output logic            inst_rd_en,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] inst_id,
  output logic [XLEN-1:0] pc_id
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = DEPTH;
  localparam logic [XLEN-1:0] PcStep = 4;

  prefetchState_e  state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] drop_addr_q;
  logic [CntW-1:0] count, count_next;
  logic            push, pop, full, empty;
  fetchEntry_t     head, new_entry;

  // Redirect suppresses both queue operations; the flush takes their place.
  assign push       = clk_en & (state_q == FETCH) & inst_ready & ~redirect;
  assign pop        = clk_en & id_valid & id_ready & ~redirect;
  assign count_next = count + CntW'(push) - CntW'(pop);
  assign new_entry  = '{pc: fetch_pc_q, inst: inst_data};

  prefetch_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(fetchEntry_t)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .flush  (redirect),
    .push   (push),
    .pop    (pop),
    .wr_data(new_entry),
    .rd_data(head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Next fetch state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (count < DepthCnt && !redirect) state_d = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          // Without a response this cycle the old read is still outstanding.
          state_d = inst_ready ? FETCH : DROP;
        end else if (inst_ready) begin
          state_d = (count_next < DepthCnt) ? FETCH : IDLE;
        end
      end
      DROP: begin
        if (inst_ready) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, fetch PC and the address of a read being abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
    end else if (clk_en) begin
      state_q <= state_d;
      if (state_q == FETCH) drop_addr_q <= fetch_pc_q;
      if (redirect) fetch_pc_q <= redirect_addr;
      else if (push) fetch_pc_q <= fetch_pc_q + PcStep;
    end
  end

  // Memory-side outputs: address stays on the abandoned read until it completes.
  always_comb begin
    inst_rd_en = (state_q != IDLE);
    inst_addr  = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
  end

  // Decode-side outputs straight from the queue head.
  always_comb begin
    id_valid = ~empty;
    inst_id  = id_valid ? head.inst : NOP_INSTRUCTION;
    pc_id    = id_valid ? head.pc : '0;
  end

  logic unused_full;
  assign unused_full = full;

endmodule
